switch_allocator: RTL

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/switch_allocator.sv
// Switch allocator for a 5-port YX-routed mesh router: per-input routing FSMs, per-output
// round-robin arbitration with wormhole ownership locks, and credit-based flow control.
module switch_allocator #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned PKT_LEN      = 4,
  parameter int unsigned CREDIT_DEPTH = 4,
  localparam int unsigned CW          = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*ADDR_W-1:0]   yx_pos_i,
  input  logic [4:0]            in_empty_i,
  input  logic [5*2*ADDR_W-1:0] in_dest_i,
  output logic [4:0]            in_read_o,
  output logic [14:0]           out_sel_o,
  output logic [4:0]            out_valid_o,
  input  logic [4:0]            out_credit_ret_i,
  output logic [5*CW-1:0]       credit_cnt_o,
  output logic                  err_o
);

  localparam int unsigned NP = 5;
  localparam int unsigned DW = 2 * ADDR_W;

  typedef enum logic [1:0] {StIdle, StRouted, StActive} in_state_e;

  // Per-input state
  in_state_e  state_q    [NP];
  in_state_e  state_d    [NP];
  logic [2:0] route_q    [NP];
  logic [2:0] route_d    [NP];
  logic [7:0] flit_cnt_q [NP];
  logic [7:0] flit_cnt_d [NP];

  // Per-output state
  logic [NP-1:0] owner_vld_q, owner_vld_d;
  logic [2:0]    owner_q      [NP];
  logic [2:0]    owner_d      [NP];
  logic [2:0]    last_grant_q [NP];
  logic [2:0]    last_grant_d [NP];
  logic [CW-1:0] credit_q     [NP];
  logic [CW-1:0] credit_d     [NP];
  logic          err_q, err_d;

  logic [NP-1:0] rd, last_rd, cred_nz, send, rel, gnt_vld, won;
  logic [NP-1:0] req     [NP];
  logic [2:0]    sel_rd  [NP];
  logic [2:0]    gnt_idx [NP];
  logic [2:0]    cand;

  function automatic logic [2:0] route_yx(input logic [DW-1:0] dest, input logic [DW-1:0] pos);
    logic [ADDR_W-1:0] dy, dx, py, px;
    logic [2:0]        res;
    {dy, dx} = dest;
    {py, px} = pos;
    if (dy < py)      res = 3'd0;
    else if (dy > py) res = 3'd1;
    else if (dx < px) res = 3'd2;
    else if (dx > px) res = 3'd3;
    else              res = 3'd4;
    return res;
  endfunction

  // (base + off) mod 5 for base in 0..4 and off in 1..5
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 4'd5) sum = sum - 4'd5;
    return sum[2:0];
  endfunction

  always_comb begin
    cred_nz = '0;
    rd      = '0;
    last_rd = '0;
    for (int j = 0; j < NP; j++) cred_nz[j] = (credit_q[j] != '0);
    for (int i = 0; i < NP; i++) begin
      rd[i]      = (state_q[i] == StActive) && !in_empty_i[i] && cred_nz[route_q[i]];
      last_rd[i] = rd[i] && (flit_cnt_q[i] == 8'(PKT_LEN - 1));
    end
  end

  // Arbitration: an output may grant when free or when its owner reads its last flit now
  always_comb begin
    send    = '0;
    rel     = '0;
    gnt_vld = '0;
    won     = '0;
    cand    = '0;
    for (int j = 0; j < NP; j++) begin
      sel_rd[j]  = '0;
      gnt_idx[j] = '0;
      req[j]     = '0;
      for (int i = 0; i < NP; i++) begin
        if (rd[i] && (route_q[i] == 3'(j))) begin
          send[j]   = 1'b1;
          sel_rd[j] = 3'(i);
        end
        req[j][i] = (state_q[i] == StRouted) && (route_q[i] == 3'(j));
      end
      rel[j] = owner_vld_q[j] && last_rd[owner_q[j]];
      if (!owner_vld_q[j] || rel[j]) begin
        for (int k = 1; k <= NP; k++) begin
          cand = rr_idx(last_grant_q[j], 3'(k));
          if (!gnt_vld[j] && req[j][cand]) begin
            gnt_vld[j] = 1'b1;
            gnt_idx[j] = cand;
          end
        end
      end
    end
    for (int j = 0; j < NP; j++) begin
      if (gnt_vld[j]) won[gnt_idx[j]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      state_d[i]    = state_q[i];
      route_d[i]    = route_q[i];
      flit_cnt_d[i] = flit_cnt_q[i];
      case (state_q[i])
        StIdle: begin
          if (!in_empty_i[i]) begin
            route_d[i] = route_yx(in_dest_i[i*DW +: DW], yx_pos_i);
            state_d[i] = StRouted;
          end
        end
        StRouted: begin
          if (won[i]) begin
            state_d[i]    = StActive;
            flit_cnt_d[i] = '0;
          end
        end
        StActive: begin
          if (last_rd[i]) begin
            state_d[i]    = StIdle;
            flit_cnt_d[i] = '0;
          end else if (rd[i]) begin
            flit_cnt_d[i] = flit_cnt_q[i] + 8'd1;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    owner_vld_d = owner_vld_q;
    err_d       = err_q;
    for (int j = 0; j < NP; j++) begin
      owner_d[j]      = owner_q[j];
      last_grant_d[j] = last_grant_q[j];
      credit_d[j]     = credit_q[j];
      if (rel[j]) owner_vld_d[j] = 1'b0;
      if (gnt_vld[j]) begin
        owner_vld_d[j]  = 1'b1;
        owner_d[j]      = gnt_idx[j];
        last_grant_d[j] = gnt_idx[j];
      end
      // A send can only happen with a nonzero count, so decrement never underflows
      if (send[j] && !out_credit_ret_i[j]) begin
        credit_d[j] = credit_q[j] - CW'(1);
      end else if (!send[j] && out_credit_ret_i[j]) begin
        if (credit_q[j] == CW'(CREDIT_DEPTH)) err_d = 1'b1;
        else                                  credit_d[j] = credit_q[j] + CW'(1);
      end
    end
  end

  always_comb begin
    in_read_o    = '0;
    out_valid_o  = '0;
    out_sel_o    = '0;
    credit_cnt_o = '0;
    for (int j = 0; j < NP; j++) credit_cnt_o[j*CW +: CW] = credit_q[j];
    if (!reset) begin
      in_read_o   = rd;
      out_valid_o = send;
      for (int j = 0; j < NP; j++) begin
        out_sel_o[j*3 +: 3] = send[j] ? sel_rd[j] : (owner_vld_q[j] ? owner_q[j] : 3'd0);
      end
    end
  end

  assign err_o = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_vld_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        state_q[i]      <= StIdle;
        route_q[i]      <= '0;
        flit_cnt_q[i]   <= '0;
        owner_q[i]      <= '0;
        last_grant_q[i] <= 3'd4;
        credit_q[i]     <= CW'(CREDIT_DEPTH);
      end
    end else begin
      state_q      <= state_d;
      route_q      <= route_d;
      flit_cnt_q   <= flit_cnt_d;
      owner_vld_q  <= owner_vld_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
    end
  end

endmodule
